neocore_mem_responder: RTL and testbench

//  Memory-side responder for the NeoCore core_top imem/dmem req/ack buses.
//  - Serves 64-bit big-endian instruction fetches and 8/16/32-bit data accesses.
//  - Inserts programmable wait states, so core stall/handshake paths are exercised.
//  - Sits between core_top and a byte array; used in sim and as the FPGA BRAM front end.

---
 rtl/neocore_mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_neocore_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neocore_mem_responder.sv
// neocore_mem_responder: memory-side responder for the NeoCore imem/dmem req/ack buses.
// Serves 64-bit big-endian fetches and 8/16/32-bit big-endian data accesses from a byte
// array, with per-port programmable wait states. Byte indices wrap modulo MEM_SIZE.
// Optional feature macro: MEM_RESP_RANDOM_STALL_EN (LFSR-driven 0..3 extra wait cycles).
module neocore_mem_responder #(
    parameter int unsigned MEM_SIZE     = 65536,
    parameter int unsigned IMEM_LATENCY = 1,
    parameter int unsigned DMEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_req,
    output logic [63:0] o_imem_rdata,
    output logic        o_imem_ack,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [1:0]  i_dmem_size,
    input  logic        i_dmem_we,
    input  logic        i_dmem_req,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_ack
);

    localparam int unsigned ADDR_W = $clog2(MEM_SIZE);
    // Wide enough for latencies up to ~250 plus the optional 3 extra stall cycles.
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    // Backing store; intentionally not reset so benches can preload it.
    logic [7:0] mem [MEM_SIZE];

    logic [1:0]        r_i_state, w_i_state_nxt;
    logic [CNT_W-1:0]  r_i_cnt, w_i_cnt_nxt;
    logic              w_i_capture, w_i_latch;
    logic [31:0]       r_i_addr;
    logic [63:0]       r_i_rdata;
    logic              r_i_ack;
    logic [ADDR_W-1:0] w_i_idx [8];

    logic [1:0]        r_d_state, w_d_state_nxt;
    logic [CNT_W-1:0]  r_d_cnt, w_d_cnt_nxt;
    logic              w_d_capture, w_d_latch;
    logic [31:0]       r_d_addr;
    logic [31:0]       r_d_wdata;
    logic [1:0]        r_d_size;
    logic              r_d_we;
    logic [31:0]       r_d_rdata;
    logic              r_d_ack;
    logic [ADDR_W-1:0] w_d_idx [4];

    logic [CNT_W-1:0]  w_i_extra, w_d_extra;

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying per-transaction extra stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_i_extra = CNT_W'(r_lfsr[1:0]);
    assign w_d_extra = CNT_W'(r_lfsr[3:2]);
`else
    assign w_i_extra = '0;
    assign w_d_extra = '0;
`endif

    // Byte indices of the captured addresses, wrapped modulo MEM_SIZE by truncation.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            w_i_idx[k] = ADDR_W'(r_i_addr + 32'(k));
        end
        for (int unsigned k = 0; k < 4; k++) begin
            w_d_idx[k] = ADDR_W'(r_d_addr + 32'(k));
        end
    end

    // imem next-state: the ACK exit edge also samples req, giving LATENCY+1 throughput.
    always_comb begin
        w_i_state_nxt = r_i_state;
        w_i_cnt_nxt   = r_i_cnt;
        w_i_capture   = 1'b0;
        w_i_latch     = 1'b0;
        case (r_i_state)
            S_IDLE, S_ACK: begin
                if (i_imem_req) begin
                    w_i_capture   = 1'b1;
                    w_i_state_nxt = S_WAIT;
                    w_i_cnt_nxt   = CNT_W'(IMEM_LATENCY - 1) + w_i_extra;
                end else begin
                    w_i_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_i_cnt == '0) begin
                    w_i_latch     = 1'b1;
                    w_i_state_nxt = S_ACK;
                end else begin
                    w_i_cnt_nxt = r_i_cnt - CNT_W'(1);
                end
            end
            default: w_i_state_nxt = S_IDLE;
        endcase
    end

    // dmem next-state: same handshake as imem with its own latency and stall source.
    always_comb begin
        w_d_state_nxt = r_d_state;
        w_d_cnt_nxt   = r_d_cnt;
        w_d_capture   = 1'b0;
        w_d_latch     = 1'b0;
        case (r_d_state)
            S_IDLE, S_ACK: begin
                if (i_dmem_req) begin
                    w_d_capture   = 1'b1;
                    w_d_state_nxt = S_WAIT;
                    w_d_cnt_nxt   = CNT_W'(DMEM_LATENCY - 1) + w_d_extra;
                end else begin
                    w_d_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_d_cnt == '0) begin
                    w_d_latch     = 1'b1;
                    w_d_state_nxt = S_ACK;
                end else begin
                    w_d_cnt_nxt = r_d_cnt - CNT_W'(1);
                end
            end
            default: w_d_state_nxt = S_IDLE;
        endcase
    end

    // imem state, request capture, fetch data latch and ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_state <= S_IDLE;
            r_i_cnt   <= '0;
            r_i_addr  <= '0;
            r_i_rdata <= '0;
            r_i_ack   <= 1'b0;
        end else begin
            r_i_state <= w_i_state_nxt;
            r_i_cnt   <= w_i_cnt_nxt;
            r_i_ack   <= w_i_latch;
            if (w_i_capture) begin
                r_i_addr <= i_imem_addr;
            end
            if (w_i_latch) begin
                r_i_rdata <= {mem[w_i_idx[0]], mem[w_i_idx[1]], mem[w_i_idx[2]], mem[w_i_idx[3]],
                              mem[w_i_idx[4]], mem[w_i_idx[5]], mem[w_i_idx[6]], mem[w_i_idx[7]]};
            end
        end
    end

    // dmem state, request capture, load data latch and ack pulse; stores leave rdata alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_state <= S_IDLE;
            r_d_cnt   <= '0;
            r_d_addr  <= '0;
            r_d_wdata <= '0;
            r_d_size  <= '0;
            r_d_we    <= 1'b0;
            r_d_rdata <= '0;
            r_d_ack   <= 1'b0;
        end else begin
            r_d_state <= w_d_state_nxt;
            r_d_cnt   <= w_d_cnt_nxt;
            r_d_ack   <= w_d_latch;
            if (w_d_capture) begin
                r_d_addr  <= i_dmem_addr;
                r_d_wdata <= i_dmem_wdata;
                r_d_size  <= i_dmem_size;
                r_d_we    <= i_dmem_we;
            end
            if (w_d_latch && !r_d_we) begin
                case (r_d_size)
                    2'b00:   r_d_rdata <= {24'd0, mem[w_d_idx[0]]};
                    2'b01:   r_d_rdata <= {16'd0, mem[w_d_idx[0]], mem[w_d_idx[1]]};
                    default: r_d_rdata <= {mem[w_d_idx[0]], mem[w_d_idx[1]],
                                           mem[w_d_idx[2]], mem[w_d_idx[3]]};
                endcase
            end
        end
    end

    // Store commit; a same-edge fetch still reads the pre-store bytes.
    always_ff @(posedge clk) begin
        if (w_d_latch && r_d_we) begin
            case (r_d_size)
                2'b00: begin
                    mem[w_d_idx[0]] <= r_d_wdata[7:0];
                end
                2'b01: begin
                    mem[w_d_idx[0]] <= r_d_wdata[15:8];
                    mem[w_d_idx[1]] <= r_d_wdata[7:0];
                end
                default: begin
                    mem[w_d_idx[0]] <= r_d_wdata[31:24];
                    mem[w_d_idx[1]] <= r_d_wdata[23:16];
                    mem[w_d_idx[2]] <= r_d_wdata[15:8];
                    mem[w_d_idx[3]] <= r_d_wdata[7:0];
                end
            endcase
        end
    end

    assign o_imem_rdata = r_i_rdata;
    assign o_imem_ack   = r_i_ack;
    assign o_dmem_rdata = r_d_rdata;
    assign o_dmem_ack   = r_d_ack;

endmodule

// File: tb/tb_neocore_mem_responder.sv
// Self-checking bench for neocore_mem_responder: directed scenarios plus randomized
// accesses checked against a byte-array reference model.
module tb_neocore_mem_responder;

    localparam int unsigned MEM_SIZE = 65536;
    localparam int unsigned IL       = 1;
    localparam int unsigned DL       = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [63:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [1:0]  dmem_size;
    logic        dmem_we;
    logic        dmem_req;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int errors = 0;
    int checks = 0;

    logic [7:0]  tb_mem [MEM_SIZE];
    logic [31:0] last_load;

    neocore_mem_responder #(
        .MEM_SIZE(MEM_SIZE), .IMEM_LATENCY(IL), .DMEM_LATENCY(DL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_imem_addr(imem_addr), .i_imem_req(imem_req),
        .o_imem_rdata(imem_rdata), .o_imem_ack(imem_ack),
        .i_dmem_addr(dmem_addr), .i_dmem_wdata(dmem_wdata), .i_dmem_size(dmem_size),
        .i_dmem_we(dmem_we), .i_dmem_req(dmem_req),
        .o_dmem_rdata(dmem_rdata), .o_dmem_ack(dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat, input int lo, input int hi);
        checks++;
        assert (lat >= lo && lat <= hi) else begin
            errors++;
            $error("FAIL %s: observed latency=%0d expected %0d..%0d", tag, lat, lo, hi);
        end
    endtask

    // Reference model: plain byte array, indices modulo MEM_SIZE, big-endian assembly.
    function automatic int unsigned mi(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + 32'(k);
        return int'(s % MEM_SIZE);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < nbytes(sz); k++) v = (v << 8) | 32'(tb_mem[mi(a, k)]);
        return v;
    endfunction

    function automatic logic [63:0] model_fetch(input logic [31:0] a);
        logic [63:0] v;
        v = 0;
        for (int k = 0; k < 8; k++) v = (v << 8) | 64'(tb_mem[mi(a, k)]);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = nbytes(sz);
        for (int k = 0; k < n; k++) tb_mem[mi(a, k)] = 8'(wd >> (8 * (n - 1 - k)));
    endtask

    task automatic lat_bounds(input int lat_param, output int lo, output int hi);
        lo = lat_param + 1;
`ifdef MEM_RESP_RANDOM_STALL_EN
        hi = lat_param + 4;
`else
        hi = lat_param + 1;
`endif
    endtask

    // One dmem transaction; lat counts edges from the capture edge to the ack-visible edge.
    task automatic dmem_op(input string tag, input logic [31:0] a, input logic we,
                           input logic [1:0] sz, input logic [31:0] wd);
        int lat, lo, hi;
        logic got;
        logic [31:0] exp;
        exp = we ? last_load : model_load(a, sz);
        dmem_addr = a; dmem_we = we; dmem_size = sz; dmem_wdata = wd; dmem_req = 1'b1;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            lat++;
            if (dmem_ack) begin
                got = 1'b1;
                break;
            end
        end
        dmem_req = 1'b0;
        dmem_addr = $urandom; dmem_wdata = $urandom;
        check({tag, " ack"}, 64'(got), 64'd1);
        lat_bounds(DL, lo, hi);
        check_lat({tag, " lat"}, lat, lo, hi);
        check({tag, " rdata"}, 64'(dmem_rdata), 64'(exp));
        if (we) model_store(a, sz, wd);
        else last_load = exp;
        @(posedge clk); #1;
        check({tag, " ack pulse"}, 64'(dmem_ack), 64'd0);
    endtask

    task automatic imem_op(input string tag, input logic [31:0] a, input logic [63:0] exp);
        int lat, lo, hi;
        logic got;
        imem_addr = a; imem_req = 1'b1;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            lat++;
            if (imem_ack) begin
                got = 1'b1;
                break;
            end
        end
        imem_req = 1'b0;
        imem_addr = $urandom;
        check({tag, " ack"}, 64'(got), 64'd1);
        lat_bounds(IL, lo, hi);
        check_lat({tag, " lat"}, lat, lo, hi);
        check({tag, " rdata"}, imem_rdata, exp);
        @(posedge clk); #1;
        check({tag, " ack pulse"}, 64'(imem_ack), 64'd0);
    endtask

    initial begin
        int n_ack, last_c, extra;
        logic [31:0] a;
        logic [7:0] b;
        logic [63:0] d;

        rst_n = 1'b0;
        imem_addr = '0; imem_req = 1'b0;
        dmem_addr = '0; dmem_wdata = '0; dmem_size = '0; dmem_we = 1'b0; dmem_req = 1'b0;
        last_load = '0;

        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            b = 8'($urandom);
            dut.mem[i] = b;
            tb_mem[i]  = b;
        end
        d = 64'h0009010005000902;
        for (int i = 0; i < 8; i++) begin
            b = 8'(d >> (56 - 8 * i));
            dut.mem[i] = b;
            tb_mem[i]  = b;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset imem_ack", 64'(imem_ack), 64'd0);
        check("reset dmem_ack", 64'(dmem_ack), 64'd0);
        check("reset imem_rdata", imem_rdata, 64'd0);
        check("reset dmem_rdata", 64'(dmem_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Big-endian 64-bit fetch of the preloaded program bytes.
        imem_op("fetch0", 32'h0, 64'h0009010005000902);

        // Word store then sub-word loads inside it.
        dmem_op("st word", 32'h100, 1'b1, 2'b10, 32'hDEADBEEF);
        check("mem100", 64'(dut.mem[16'h100]), 64'hDE);
        check("mem101", 64'(dut.mem[16'h101]), 64'hAD);
        check("mem102", 64'(dut.mem[16'h102]), 64'hBE);
        check("mem103", 64'(dut.mem[16'h103]), 64'hEF);
        dmem_op("ld byte", 32'h101, 1'b0, 2'b00, 32'h0);
        check("ld byte const", 64'(dmem_rdata), 64'h000000AD);
        dmem_op("ld half", 32'h102, 1'b0, 2'b01, 32'h0);
        check("ld half const", 64'(dmem_rdata), 64'h0000BEEF);
        dmem_op("ld size3", 32'h100, 1'b0, 2'b11, 32'h0);
        check("ld size3 const", 64'(dmem_rdata), 64'hDEADBEEF);

        // Top-of-memory wrap.
        dmem_op("st top", 32'hFFFF, 1'b1, 2'b00, 32'hFFFFFF5A);
        check("memFFFF", 64'(dut.mem[16'hFFFF]), 64'h5A);
        dmem_op("ld wrap", 32'hFFFF, 1'b0, 2'b01, 32'h0);
        check("ld wrap hi", 64'(dmem_rdata[15:8]), 64'h5A);
        imem_op("fetch wrap", 32'h0000FFFC, model_fetch(32'h0000FFFC));

        // Held imem_req: four back-to-back transactions.
        imem_addr = 32'h10; imem_req = 1'b1;
        n_ack = 0; last_c = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (imem_ack) begin
                n_ack++;
                check("b2b rdata", imem_rdata, model_fetch(32'h10));
`ifndef MEM_RESP_RANDOM_STALL_EN
                if (last_c >= 0) check("b2b spacing", 64'(c - last_c), 64'(IL + 1));
`endif
                last_c = c;
                if (n_ack == 4) begin
                    imem_req = 1'b0;
                    break;
                end
            end
        end
        imem_req = 1'b0;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (imem_ack) extra++;
        end
        check("b2b ack count", 64'(n_ack), 64'd4);
        check("b2b no extra ack", 64'(extra), 64'd0);

`ifndef MEM_RESP_RANDOM_STALL_EN
        // Store and overlapping fetch latching on the same edge: fetch sees old bytes.
        begin
            logic dg, ig;
            int dc, ic;
            logic [63:0] idata, iexp;
            iexp = model_fetch(32'h1FE);
            dmem_addr = 32'h200; dmem_wdata = 32'hCAFEF00D; dmem_size = 2'b10;
            dmem_we = 1'b1; dmem_req = 1'b1;
            @(posedge clk); #1;
            imem_addr = 32'h1FE; imem_req = 1'b1;
            dg = 1'b0; ig = 1'b0; dc = -1; ic = -1; idata = '0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (dmem_ack && !dg) begin dg = 1'b1; dc = c; dmem_req = 1'b0; end
                if (imem_ack && !ig) begin ig = 1'b1; ic = c; idata = imem_rdata; imem_req = 1'b0; end
                if (dg && ig) break;
            end
            dmem_req = 1'b0; imem_req = 1'b0;
            check("coll d cycle", 64'(dc), 64'd1);
            check("coll i cycle", 64'(ic), 64'd1);
            check("coll fetch old", idata, iexp);
            model_store(32'h200, 2'b10, 32'hCAFEF00D);
            check("coll stored", 64'({dut.mem[16'h200], dut.mem[16'h201],
                                      dut.mem[16'h202], dut.mem[16'h203]}), 64'hCAFEF00D);
            @(posedge clk); #1;
        end
`endif

        // Randomized data and fetch traffic against the model.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFC + 32'($urandom_range(0, 3)))
                                             : 32'($urandom);
            dmem_op("rnd d", a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 2) == 0) ? (32'hFFF8 + 32'($urandom_range(0, 7)))
                                             : 32'($urandom);
            imem_op("rnd i", a, model_fetch(a));
        end

        // Reset in the middle of a store's wait: store discarded, no ack.
        dmem_addr = 32'h20; dmem_wdata = 32'h11223344; dmem_size = 2'b10;
        dmem_we = 1'b1; dmem_req = 1'b1;
        @(posedge clk); #1;
        check("abort pre ack", 64'(dmem_ack), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort imem_ack", 64'(imem_ack), 64'd0);
        check("abort dmem_ack", 64'(dmem_ack), 64'd0);
        check("abort imem_rdata", imem_rdata, 64'd0);
        check("abort dmem_rdata", 64'(dmem_rdata), 64'd0);
        dmem_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort held dmem_ack", 64'(dmem_ack), 64'd0);
        check("abort held dmem_rdata", 64'(dmem_rdata), 64'd0);
        for (int k = 0; k < 4; k++) check("abort mem", 64'(dut.mem[16'h20 + 16'(k)]), 64'(tb_mem[32 + k]));
        rst_n = 1'b1;
        last_load = '0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (dmem_ack || imem_ack) extra++;
        end
        check("abort no ack after", 64'(extra), 64'd0);
        dmem_op("post reset ld", 32'h20, 1'b0, 2'b10, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
